// File: rtl/rom_reader_pkg.sv
// Shared state encoding and default geometry for the ROM stream reader.
package rom_reader_pkg;

    localparam int AW_DEF    = 6;
    localparam int DW_DEF    = 4;
    localparam int DEPTH_DEF = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with occupancy count; DEPTH must be a power of two.
module sync_fifo #(
    parameter int W     = 5,
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic                         pop,
    input  logic [W-1:0]                 din,
    output logic [W-1:0]                 dout,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty,
    output logic                         full
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the storage is only a couple of entries, so it is reset to give m_data a defined 0 out of reset.
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (do_pop) rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign dout  = mem[rd_ptr];
    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));

endmodule

// File: rtl/rom_stream_reader.sv
// Reads a block of words from a 1-cycle synchronous ROM and streams them out.
// Define ROM_READER_ADDR_ECHO_EN to add m_addr, the ROM address of each streamed word.
module rom_stream_reader
    import rom_reader_pkg::*;
#(
    parameter int AW    = AW_DEF,
    parameter int DW    = DW_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [AW-1:0] start_addr,
    input  logic [AW:0]   length,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] rom_addr,
    input  logic [DW-1:0] rom_data,
    output logic [DW-1:0] m_data,
    output logic          m_valid,
    input  logic          m_ready,
`ifdef ROM_READER_ADDR_ECHO_EN
    output logic [AW-1:0] m_addr,
`endif
    output logic          m_last
);

    localparam int CW = $clog2(DEPTH+1);
`ifdef ROM_READER_ADDR_ECHO_EN
    localparam int FW = 1 + AW + DW;
`else
    localparam int FW = 1 + DW;
`endif

    state_t        state;
    state_t        state_nxt;
    logic [AW:0]   remaining;
    logic          inflight;
    logic          inflight_last;
    logic          issue;
    logic          pop;
    logic          drain_finish;
    logic          done_nxt;
    logic          cmd_accept;
    logic [CW:0]   credits_used;
    logic [FW-1:0] fifo_din;
    logic [FW-1:0] fifo_dout;
    logic [CW-1:0] fifo_count;
    logic          fifo_empty;
    logic          fifo_full;
`ifdef ROM_READER_ADDR_ECHO_EN
    logic [AW-1:0] inflight_addr;
`endif

    // A word popped this cycle frees its slot in time for a word issued now,
    // which is what lets a DEPTH=2 FIFO sustain one beat per cycle.
    assign credits_used = {1'b0, fifo_count} + {{CW{1'b0}}, inflight} - {{CW{1'b0}}, pop};
    assign issue        = (state == ST_RUN) && (credits_used < (CW+1)'(DEPTH));
    assign cmd_accept   = (state == ST_IDLE) && start && (length != '0);
    assign drain_finish = (state == ST_DRAIN) && !inflight &&
                          (fifo_empty || (fifo_count == CW'(1) && pop));

    // NOTE: every comb output gets a default before the case so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        done_nxt  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    if (length != '0) state_nxt = ST_RUN;
                    else              done_nxt  = 1'b1;
                end
            end
            ST_RUN: begin
                if (issue && remaining == (AW+1)'(1)) state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (drain_finish) begin
                    state_nxt = ST_IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rom_addr      <= '0;
            remaining     <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            done          <= 1'b0;
`ifdef ROM_READER_ADDR_ECHO_EN
            inflight_addr <= '0;
`endif
        end else begin
            done     <= done_nxt;
            inflight <= issue;
            if (cmd_accept) begin
                rom_addr  <= start_addr;
                remaining <= length;
            end else if (issue) begin
                remaining     <= remaining - (AW+1)'(1);
                inflight_last <= (remaining == (AW+1)'(1));
`ifdef ROM_READER_ADDR_ECHO_EN
                inflight_addr <= rom_addr;
`endif
                // The final address stays on the port once the block is fully issued.
                if (remaining != (AW+1)'(1)) rom_addr <= rom_addr + AW'(1);
            end
        end
    end

`ifdef ROM_READER_ADDR_ECHO_EN
    assign fifo_din = {inflight_last, inflight_addr, rom_data};
    assign m_addr   = fifo_dout[AW+DW-1:DW];
`else
    assign fifo_din = {inflight_last, rom_data};
`endif

    sync_fifo #(
        .W     (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (inflight),
        .pop   (pop),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .count (fifo_count),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    assign m_valid = !fifo_empty;
    assign pop     = m_valid && m_ready;
    assign m_data  = fifo_dout[DW-1:0];
    assign m_last  = fifo_dout[FW-1];
    assign busy    = (state != ST_IDLE);

    // A returning word must always find room; the credit check guarantees it.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(inflight && fifo_full && !pop));

endmodule

// File: tb/tb_rom_stream_reader.sv
// Directed, table-driven bench for rom_stream_reader with a 1-cycle ROM model (mem[i] = i[3:0]).
module tb_rom_stream_reader;
    import rom_reader_pkg::*;

    localparam int AW = AW_DEF;
    localparam int DW = DW_DEF;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] start_addr = '0;
    logic [AW:0]   length = '0;
    logic          busy;
    logic          done;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_data = '0;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic          m_last;
`ifdef ROM_READER_ADDR_ECHO_EN
    logic [AW-1:0] m_addr;
`endif

    int total  = 0;
    int passed = 0;

    logic [DW-1:0] rom_mem [2**AW];
    logic [0:5]    ready_pat = 6'b100101;

    typedef struct {
        logic [AW-1:0] addr;
        logic [AW:0]   len;
        bit            toggle;
        bit            intrude;
        logic [DW-1:0] first_data;
        logic [DW-1:0] final_data;
    } vec_t;

    vec_t vecs [6];

    rom_stream_reader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .start_addr (start_addr),
        .length     (length),
        .busy       (busy),
        .done       (done),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
`ifdef ROM_READER_ADDR_ECHO_EN
        .m_addr     (m_addr),
`endif
        .m_last     (m_last)
    );

    always #5 clk = ~clk;

    initial for (int i = 0; i < 2**AW; i++) rom_mem[i] = DW'(i);
    always @(posedge clk) rom_data <= rom_mem[rom_addr];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        else             passed++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_stream(input vec_t v, input string tag);
        int            k           = 0;
        int            cyc         = 0;
        int            first_valid = -1;
        int            max_cnt     = 0;
        bit            fin         = 0;
        bit            early_done  = 0;
        bit            prev_stall  = 0;
        logic [DW-1:0] prev_data   = '0;
        logic          prev_last   = 1'b0;
        logic [DW-1:0] got_first   = '0;
        logic [DW-1:0] got_final   = '0;
        logic [AW-1:0] exp_addr;

        start      = 1'b1;
        start_addr = v.addr;
        length     = v.len;
        step();
        start = 1'b0;
        check({tag, " busy_after_start"}, busy, 1);

        while (!fin && cyc < 300) begin
            if (v.intrude && cyc == 1) begin
                start      = 1'b1;
                start_addr = 6'd9;
                length     = 7'd3;
            end else begin
                start = 1'b0;
            end
            m_ready = v.toggle ? ready_pat[cyc % 6] : 1'b1;
            if (done) early_done = 1;
            if (int'(dut.fifo_count) > max_cnt) max_cnt = int'(dut.fifo_count);
            if (m_valid && first_valid < 0) first_valid = cyc;

            if (!v.toggle && cyc < int'(v.len)) begin
                exp_addr = v.addr + AW'(cyc);
                check({tag, " rom_addr"}, rom_addr, exp_addr);
            end

            if (prev_stall)
                check({tag, " hold_valid_last_data"}, {m_valid, m_last, m_data},
                      {1'b1, prev_last, prev_data});
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_last  = m_last;

            if (m_valid && m_ready) begin
                exp_addr = v.addr + AW'(k);
                check({tag, " data"}, m_data, exp_addr[DW-1:0]);
                check({tag, " last"}, m_last, (k == int'(v.len) - 1));
`ifdef ROM_READER_ADDR_ECHO_EN
                check({tag, " m_addr"}, m_addr, exp_addr);
`endif
                if (k == 0) got_first = m_data;
                got_final = m_data;
                k++;
                if (k == int'(v.len)) begin
                    start = 1'b0;
                    step();
                    check({tag, " done_after_last"}, done, 1);
                    check({tag, " busy_at_done"}, busy, 0);
                    check({tag, " valid_at_done"}, m_valid, 0);
                    fin = 1;
                end
            end
            if (!fin) begin
                step();
                cyc++;
            end
        end

        if (!fin) check({tag, " timeout"}, 1, 0);
        check({tag, " first_valid_latency"}, first_valid, 2);
        check({tag, " beat_count"}, k, int'(v.len));
        check({tag, " first_data"}, got_first, v.first_data);
        check({tag, " final_data"}, got_final, v.final_data);
        check({tag, " no_early_done"}, early_done, 0);
        check({tag, " fifo_count_max"}, (max_cnt <= 2), 1);
        m_ready = 1'b0;
        step();
        check({tag, " done_one_cycle"}, done, 0);
        check({tag, " busy_idle"}, busy, 0);
    endtask

    initial begin
        int hs;
        vec_t v;

        vecs[0] = '{addr: 6'd5,  len: 7'd4,  toggle: 0, intrude: 0, first_data: 4'd5,  final_data: 4'd8};
        vecs[1] = '{addr: 6'd62, len: 7'd4,  toggle: 0, intrude: 0, first_data: 4'd14, final_data: 4'd1};
        vecs[2] = '{addr: 6'd0,  len: 7'd6,  toggle: 1, intrude: 0, first_data: 4'd0,  final_data: 4'd5};
        vecs[3] = '{addr: 6'd5,  len: 7'd4,  toggle: 0, intrude: 1, first_data: 4'd5,  final_data: 4'd8};
        vecs[4] = '{addr: 6'd7,  len: 7'd1,  toggle: 0, intrude: 0, first_data: 4'd7,  final_data: 4'd7};
        vecs[5] = '{addr: 6'd33, len: 7'd64, toggle: 0, intrude: 0, first_data: 4'd1,  final_data: 4'd0};

        repeat (2) @(posedge clk);
        #1;
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset rom_addr", rom_addr, 0);
        check("reset m_valid", m_valid, 0);
        check("reset m_last", m_last, 0);
        check("reset m_data", m_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 6; i++) begin
            run_stream(vecs[i], $sformatf("vec%0d", i));
        end

        // Zero-length command: immediate done, no beats, never busy.
        start      = 1'b1;
        start_addr = 6'd20;
        length     = 7'd0;
        step();
        start = 1'b0;
        check("len0 done", done, 1);
        check("len0 busy", busy, 0);
        check("len0 m_valid", m_valid, 0);
        step();
        check("len0 done_clear", done, 0);
        check("len0 busy_idle", busy, 0);
        check("len0 m_valid_idle", m_valid, 0);

        // Asynchronous reset in the middle of a block, then a fresh command.
        m_ready    = 1'b1;
        start      = 1'b1;
        start_addr = 6'd10;
        length     = 7'd6;
        step();
        start = 1'b0;
        hs = 0;
        for (int c = 0; c < 20 && hs < 2; c++) begin
            if (m_valid && m_ready) hs++;
            step();
        end
        check("rst_mid handshakes", hs, 2);
        check("rst_mid busy_before", busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid busy", busy, 0);
        check("rst_mid done", done, 0);
        check("rst_mid rom_addr", rom_addr, 0);
        check("rst_mid m_valid", m_valid, 0);
        check("rst_mid m_last", m_last, 0);
        check("rst_mid m_data", m_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        v = '{addr: 6'd3, len: 7'd2, toggle: 0, intrude: 0, first_data: 4'd3, final_data: 4'd4};
        run_stream(v, "after_reset");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
